// File: rtl/pio_rx_engine.sv
// pio_rx_engine: PCIe RX request decoder for single-DW memory reads and writes.
// Turns 64-bit AXI-Stream RX TLPs into BAR0/BAR2 write strobes or held read
// addresses plus a completion request. It stalls reception while one request
// is outstanding.
module pio_rx_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] m_axis_rx_tdata,
    input  logic [7:0]  m_axis_rx_tkeep,
    input  logic        m_axis_rx_tlast,
    input  logic        m_axis_rx_tvalid,
    output logic        m_axis_rx_tready,
    input  logic [21:0] m_axis_rx_tuser,
    output logic [13:0] rd_addr,
    output logic [3:0]  rd_be,
    output logic        wr_en,
    output logic [13:0] wr_addr,
    output logic [7:0]  wr_be,
    output logic [31:0] wr_data,
    input  logic        wr_busy,
    output logic        req_compl,
    input  logic        compl_done,
    output logic [2:0]  req_tc,
    output logic        req_td,
    output logic        req_ep,
    output logic [1:0]  req_attr,
    output logic [9:0]  req_len,
    output logic [15:0] req_rid,
    output logic [7:0]  req_tag,
    output logic [7:0]  req_be,
    output logic [12:0] req_addr
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] RD32_QW1 = 4'd1;
    localparam logic [3:0] WR32_QW1 = 4'd2;
    localparam logic [3:0] RD64_QW1 = 4'd3;
    localparam logic [3:0] WR64_QW1 = 4'd4;
    localparam logic [3:0] WR64_QW2 = 4'd5;
    localparam logic [3:0] WAIT_CPL = 4'd6;
    localparam logic [3:0] WAIT_WR  = 4'd7;
    localparam logic [3:0] DRAIN    = 4'd8;

    localparam logic [7:0] FT_MRD32 = 8'h00;
    localparam logic [7:0] FT_MRD64 = 8'h20;
    localparam logic [7:0] FT_MWR32 = 8'h40;
    localparam logic [7:0] FT_MWR64 = 8'h60;

    logic [3:0]  r_state, w_next;
    logic        r_tready;
    logic [1:0]  r_region;
    logic [2:0]  r_tc;
    logic        r_td, r_ep;
    logic [1:0]  r_attr;
    logic [15:0] r_rid;
    logic [7:0]  r_tag;
    logic [3:0]  r_lbe, r_fbe;
    logic [11:0] r_addr;      // addr[13:2] of a 4DW write, held until its data beat

    logic        w_beat, w_last;
    logic [7:0]  w_ft;
    logic        w_is_rd, w_is_wr, w_bar0, w_bar2, w_accept;
    logic        w_fin_rd, w_fin_wr;
    logic [11:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_unused;

    assign w_beat   = m_axis_rx_tvalid & r_tready;
    assign w_last   = m_axis_rx_tlast;
    assign w_ft     = m_axis_rx_tdata[31:24];
    assign w_is_rd  = (w_ft == FT_MRD32) | (w_ft == FT_MRD64);
    assign w_is_wr  = (w_ft == FT_MWR32) | (w_ft == FT_MWR64);
    assign w_bar0   = m_axis_rx_tuser[2];
    assign w_bar2   = m_axis_rx_tuser[4];
    // Poisoned writes are dropped; poisoned reads are still answered.
    assign w_accept = (w_is_rd | (w_is_wr & ~m_axis_rx_tdata[14])) &
                      (m_axis_rx_tdata[9:0] == 10'd1) & (w_bar0 | w_bar2);

    assign w_fin_rd = w_beat & w_last & ((r_state == RD32_QW1) | (r_state == RD64_QW1));
    assign w_fin_wr = w_beat & w_last & ((r_state == WR32_QW1) | (r_state == WR64_QW2));

    assign w_wdata  = (r_state == WR64_QW2) ? m_axis_rx_tdata[31:0] : m_axis_rx_tdata[63:32];
    assign w_unused = ^{m_axis_rx_tkeep, m_axis_rx_tuser[21:5], m_axis_rx_tuser[3],
                        m_axis_rx_tuser[1:0]};

    assign m_axis_rx_tready = r_tready;

    // DW address source depends on header length and which beat carries it
    always_comb begin
        w_addr = m_axis_rx_tdata[13:2];
        case (r_state)
            RD64_QW1: w_addr = m_axis_rx_tdata[45:34];
            WR64_QW2: w_addr = r_addr;
            default:  w_addr = m_axis_rx_tdata[13:2];
        endcase
    end

    // Next-state decode; a missing or premature tlast discards the TLP
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:
                if (w_beat && !w_last) begin
                    if (!w_accept)                 w_next = DRAIN;
                    else if (w_ft == FT_MRD32)     w_next = RD32_QW1;
                    else if (w_ft == FT_MRD64)     w_next = RD64_QW1;
                    else if (w_ft == FT_MWR32)     w_next = WR32_QW1;
                    else                           w_next = WR64_QW1;
                end
            RD32_QW1, RD64_QW1:
                if (w_beat) w_next = w_last ? WAIT_CPL : DRAIN;
            WR32_QW1:
                if (w_beat) w_next = w_last ? WAIT_WR : DRAIN;
            WR64_QW1:
                if (w_beat) w_next = w_last ? IDLE : WR64_QW2;
            WR64_QW2:
                if (w_beat) w_next = w_last ? WAIT_WR : DRAIN;
            WAIT_CPL:
                if (compl_done) w_next = IDLE;
            WAIT_WR:
                if (!wr_busy) w_next = IDLE;
            DRAIN:
                if (w_beat && w_last) w_next = IDLE;
            default:
                w_next = IDLE;
        endcase
    end

    // State and tready registers; tready is registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tready <= (w_next != WAIT_CPL) && (w_next != WAIT_WR);
        end
    end

    // Header capture and request outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_region  <= 2'b00;
            r_tc      <= 3'd0;
            r_td      <= 1'b0;
            r_ep      <= 1'b0;
            r_attr    <= 2'b00;
            r_rid     <= 16'd0;
            r_tag     <= 8'd0;
            r_lbe     <= 4'd0;
            r_fbe     <= 4'd0;
            r_addr    <= 12'd0;
            rd_addr   <= 14'd0;
            rd_be     <= 4'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 14'd0;
            wr_be     <= 8'd0;
            wr_data   <= 32'd0;
            req_compl <= 1'b0;
            req_tc    <= 3'd0;
            req_td    <= 1'b0;
            req_ep    <= 1'b0;
            req_attr  <= 2'b00;
            req_len   <= 10'd0;
            req_rid   <= 16'd0;
            req_tag   <= 8'd0;
            req_be    <= 8'd0;
            req_addr  <= 13'd0;
        end else begin
            wr_en <= 1'b0;
            if (r_state == IDLE && w_beat && !w_last) begin
                r_region <= w_bar0 ? 2'b01 : 2'b10;
                r_tc     <= m_axis_rx_tdata[22:20];
                r_td     <= m_axis_rx_tdata[15];
                r_ep     <= m_axis_rx_tdata[14];
                r_attr   <= m_axis_rx_tdata[13:12];
                r_rid    <= m_axis_rx_tdata[63:48];
                r_tag    <= m_axis_rx_tdata[47:40];
                r_lbe    <= m_axis_rx_tdata[39:36];
                r_fbe    <= m_axis_rx_tdata[35:32];
            end
            if (r_state == WR64_QW1 && w_beat)
                r_addr <= m_axis_rx_tdata[45:34];
            if (w_fin_wr) begin
                wr_en   <= 1'b1;
                wr_addr <= {r_region, w_addr};
                wr_be   <= {4'b0000, r_fbe};
                wr_data <= w_wdata;
            end
            if (w_fin_rd) begin
                rd_addr   <= {r_region, w_addr};
                rd_be     <= r_fbe;
                req_compl <= 1'b1;
                req_tc    <= r_tc;
                req_td    <= r_td;
                req_ep    <= r_ep;
                req_attr  <= r_attr;
                req_len   <= 10'd1;
                req_rid   <= r_rid;
                req_tag   <= r_tag;
                req_be    <= {r_lbe, r_fbe};
                req_addr  <= {w_addr[10:0], 2'b00};
            end else if (r_state == WAIT_CPL && compl_done) begin
                req_compl <= 1'b0;
            end
        end
    end

endmodule
